// File: rtl/strhw_hash_ctrl.sv
// Purpose : Streebog (GOST 34.11-2018) hash sequencer. Pads the final block, keeps h/N/Sigma,
//           drives an external g_N core via start/done and runs the N and Sigma finalisation steps.
// Latency : g_start one cycle after a block transfer or after the previous g_done; digest_valid
//           one cycle after the last g_done.
// Backpressure: blk_ready only while awaiting a block; at most one compression outstanding.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   start, mode256           begin hash (accepted in CLEAR/DONE); mode256=1 selects 256-bit digest
//   blk_valid/ready/data     64-byte block stream, byte k at [8k+7:8k]
//   blk_last, blk_bytes      final-block marker and its byte count (0..64)
//   g_start, g_h, g_n, g_m   compression request and operands (held until g_done)
//   g_done, g_result         compression completion and new h
//   status                   CLEAR / READY / BUSY / DONE
//   digest, digest_valid     result; 256 mode returns h[511:256] in the low half
//   err                      sticky protocol error, cleared by an accepted start

package strhw_common_types;
  localparam int BLOCK_SIZE = 64;
  localparam logic [511:0] INIT_VECTOR_512 = '0;
  localparam logic [511:0] INIT_VECTOR_256 = {64{8'h01}};
  typedef enum logic [1:0] {CLEAR = 2'd0, READY = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;
endpackage

module strhw_hash_ctrl
  import strhw_common_types::*;
#(
  parameter int BLOCK_BYTES = 64,
  parameter int DEBUG       = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode256,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  input  logic [6:0]   blk_bytes,
  output logic         g_start,
  output logic [511:0] g_h,
  output logic [511:0] g_n,
  output logic [511:0] g_m,
  input  logic         g_done,
  input  logic [511:0] g_result,
  output logic [1:0]   status,
  output logic [511:0] digest,
  output logic         digest_valid,
  output logic         err
);

  if (BLOCK_BYTES != BLOCK_SIZE || DEBUG < 0 || DEBUG > 1) begin : g_bad_param
    $error("strhw_hash_ctrl: BLOCK_BYTES must equal BLOCK_SIZE and DEBUG must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_COMP_BLK, S_COMP_PAD, S_FIN_N, S_FIN_S, S_DONE
  } fsm_t;

  fsm_t         state, state_nx;
  logic [511:0] h, n_cnt, sigma;
  logic [511:0] m_pad, n_inc, n_sum, sig_sum;
  logic         mode_q, last_q;
  logic [6:0]   bytes_q;
  logic         xfer, bad_len;

  assign xfer    = blk_valid & blk_ready;
  assign bad_len = blk_last && (blk_bytes > 7'd64);

  // Final short block: keep bytes below b, put the 0x01 marker at b, clear everything above.
  always_comb begin
    m_pad = blk_data;
    if (blk_last && (blk_bytes < 7'd64)) begin
      for (int k = 0; k < 64; k++) begin
        if (7'(k) == blk_bytes)
          m_pad[8*k +: 8] = 8'h01;
        else if (7'(k) > blk_bytes)
          m_pad[8*k +: 8] = 8'h00;
      end
    end
  end

  // A full 64-byte last block still advances N by 512; only a short one adds 8*b.
  assign n_inc   = (last_q && (bytes_q != 7'd64)) ? {502'd0, bytes_q, 3'd0} : 512'd512;
  assign n_sum   = n_cnt + n_inc;
  // g_m still holds the block just compressed, so it doubles as the Sigma addend.
  assign sig_sum = sigma + g_m;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    blk_ready    = 1'b0;
    status       = BUSY;
    digest_valid = 1'b0;
    case (state)
      S_IDLE: begin
        status = CLEAR;
        if (start) state_nx = S_WAIT;
      end
      S_WAIT: begin
        status    = READY;
        blk_ready = 1'b1;
        if (xfer) state_nx = bad_len ? S_IDLE : S_COMP_BLK;
      end
      S_COMP_BLK: begin
        if (g_done) begin
          if (!last_q)               state_nx = S_WAIT;
          else if (bytes_q == 7'd64) state_nx = S_COMP_PAD;
          else                       state_nx = S_FIN_N;
        end
      end
      S_COMP_PAD: if (g_done) state_nx = S_FIN_N;
      S_FIN_N:    if (g_done) state_nx = S_FIN_S;
      S_FIN_S:    if (g_done) state_nx = S_DONE;
      S_DONE: begin
        status       = DONE;
        digest_valid = 1'b1;
        if (start) state_nx = S_WAIT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h       <= '0;
      n_cnt   <= '0;
      sigma   <= '0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      bytes_q <= '0;
      g_start <= 1'b0;
      g_h     <= '0;
      g_n     <= '0;
      g_m     <= '0;
      digest  <= '0;
      err     <= 1'b0;
    end else begin
      g_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            h      <= mode256 ? INIT_VECTOR_256 : INIT_VECTOR_512;
            n_cnt  <= '0;
            sigma  <= '0;
            mode_q <= mode256;
            err    <= 1'b0;
          end
        end
        S_WAIT: begin
          if (xfer) begin
            last_q  <= blk_last;
            bytes_q <= blk_bytes;
            if (bad_len) begin
              err <= 1'b1;
            end else begin
              g_start <= 1'b1;
              g_h     <= h;
              g_n     <= n_cnt;
              g_m     <= m_pad;
            end
          end
        end
        S_COMP_BLK: begin
          if (g_done) begin
            h     <= g_result;
            n_cnt <= n_sum;
            sigma <= sig_sum;
            if (last_q) begin
              g_start <= 1'b1;
              g_h     <= g_result;
              if (bytes_q == 7'd64) begin
                // Extra padding-only block; its N operand already includes this block.
                g_n <= n_sum;
                g_m <= 512'd1;
              end else begin
                g_n <= '0;
                g_m <= n_sum;
              end
            end
          end
        end
        S_COMP_PAD: begin
          if (g_done) begin
            h       <= g_result;
            sigma   <= sig_sum;
            g_start <= 1'b1;
            g_h     <= g_result;
            g_n     <= '0;
            g_m     <= n_cnt;
          end
        end
        S_FIN_N: begin
          if (g_done) begin
            h       <= g_result;
            g_start <= 1'b1;
            g_h     <= g_result;
            g_n     <= '0;
            g_m     <= sigma;
          end
        end
        S_FIN_S: begin
          if (g_done) begin
            h      <= g_result;
            digest <= mode_q ? {256'd0, g_result[511:256]} : g_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_strhw_hash_ctrl.sv
module tb_strhw_hash_ctrl;

  typedef struct packed {
    logic [511:0] h;
    logic [511:0] n;
    logic [511:0] m;
  } op_t;

  localparam logic [511:0] KMIX = {8{64'h9e3779b97f4a7c15}};

  logic         clk, rst, start, mode256, blk_valid, blk_ready, blk_last;
  logic [511:0] blk_data, g_h, g_n, g_m, g_result, digest;
  logic [6:0]   blk_bytes;
  logic         g_start, g_done, digest_valid, err;
  logic [1:0]   status;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cyc = -10;
  int lat_lo = 1;
  int lat_hi = 4;

  op_t          got_q[$];
  op_t          exp_q[$];
  logic [7:0]   msg_q[$];
  logic [511:0] exp_digest, exp_sigma, exp_n, dig_obs;

  strhw_hash_ctrl #(.BLOCK_BYTES(64), .DEBUG(0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode256(mode256),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .blk_bytes(blk_bytes),
    .g_start(g_start), .g_h(g_h), .g_n(g_n), .g_m(g_m),
    .g_done(g_done), .g_result(g_result),
    .status(status), .digest(digest), .digest_valid(digest_valid), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (g_done === 1'b1) done_cyc = cyc;

  // Stand-in compression function shared by the core emulation and the reference model.
  function automatic logic [511:0] gfun(input logic [511:0] h, input logic [511:0] n,
                                        input logic [511:0] m);
    return ({h[500:0], h[511:501]} ^ (n * 512'd3)) + (m ^ KMIX);
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compression core emulation: records operands at g_start, answers after a random latency.
  initial begin : core
    op_t o;
    int  lat;
    g_done   = 1'b0;
    g_result = '0;
    forever begin
      @(negedge clk);
      if (g_start === 1'b1) begin
        o.h = g_h;
        o.n = g_n;
        o.m = g_m;
        got_q.push_back(o);
        lat = $urandom_range(lat_hi, lat_lo);
        repeat (lat) @(posedge clk);
        #1;
        g_done   = 1'b1;
        g_result = gfun(o.h, o.n, o.m);
        @(posedge clk);
        #1;
        g_done = 1'b0;
      end
    end
  end

  // Reference: whole-message Streebog sequencing from msg_q.
  task automatic model_run(input bit m256);
    logic [511:0] h, nn, s, m;
    int len, nblk, lastb, b;
    len   = msg_q.size();
    nblk  = (len == 0) ? 1 : (len + 63) / 64;
    lastb = len - 64 * (nblk - 1);
    exp_q.delete();
    h  = m256 ? {64{8'h01}} : '0;
    nn = '0;
    s  = '0;
    for (int i = 0; i < nblk; i++) begin
      b = (i == nblk - 1) ? lastb : 64;
      m = '0;
      for (int k = 0; k < b; k++) m[8*k +: 8] = msg_q[64*i + k];
      if (b < 64) m[8*b +: 8] = 8'h01;
      exp_q.push_back({h, nn, m});
      h  = gfun(h, nn, m);
      nn = nn + 512'(8 * b);
      s  = s + m;
    end
    if (lastb == 64) begin
      exp_q.push_back({h, nn, 512'd1});
      h = gfun(h, nn, 512'd1);
      s = s + 512'd1;
    end
    exp_q.push_back({h, 512'd0, nn});
    h = gfun(h, 512'd0, nn);
    exp_q.push_back({h, 512'd0, s});
    h = gfun(h, 512'd0, s);
    exp_n      = nn;
    exp_sigma  = s;
    exp_digest = m256 ? {256'd0, h[511:256]} : h;
  endtask

  task automatic pulse_start(input bit m);
    @(posedge clk); #1;
    start   = 1'b1;
    mode256 = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [511:0] d, input bit last, input logic [6:0] nb, input bit stall);
    bit r;
    int t;
    if (stall) begin
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = last;
    blk_bytes = nb;
    r = 0;
    t = 0;
    while (!r && t < 500) begin
      @(negedge clk);
      r = blk_ready;
      @(posedge clk); #1;
      t++;
    end
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    if (!r) chk("feed_timeout", 512'd0, 512'd1);
  endtask

  // Splits msg_q into blocks; bytes beyond the valid count carry garbage.
  task automatic feed_msg(input bit stall);
    logic [511:0] d;
    int len, nblk, b;
    len  = msg_q.size();
    nblk = (len == 0) ? 1 : (len + 63) / 64;
    for (int i = 0; i < nblk; i++) begin
      b = (i == nblk - 1) ? len - 64 * i : 64;
      for (int k = 0; k < 64; k++)
        d[8*k +: 8] = (k < b) ? msg_q[64*i + k] : 8'($urandom);
      if (i == nblk - 1) feed(d, 1'b1, 7'(b), stall);
      else               feed(d, 1'b0, 7'($urandom), stall);
    end
  endtask

  task automatic run_hash(input string tag, input bit m256, input bit stall);
    bit seen;
    int t;
    got_q.delete();
    model_run(m256);
    pulse_start(m256);
    feed_msg(stall);
    seen = 0;
    t = 0;
    while (!seen && t < 3000) begin
      @(negedge clk);
      if (digest_valid === 1'b1) seen = 1;
      t++;
    end
    chk($sformatf("%s_done", tag), 512'(seen), 512'd1);
    dig_obs = digest;
    if (seen) chk($sformatf("%s_dv_lat", tag), 512'(cyc), 512'(done_cyc + 1));
    chk($sformatf("%s_digest", tag), digest, exp_digest);
    chk($sformatf("%s_ncomp", tag), 512'(got_q.size()), 512'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk($sformatf("%s_op%0d_n", tag, i), got_q[i].n, exp_q[i].n);
        chk($sformatf("%s_op%0d_m", tag, i), got_q[i].m, exp_q[i].m);
      end
    end
    chk($sformatf("%s_err", tag), 512'(err), 512'd0);
  endtask

  initial begin : stim
    logic [511:0] blkval;
    int t;
    rst       = 1'b1;
    start     = 1'b0;
    mode256   = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_last  = 1'b0;
    blk_bytes = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_status", 512'(status), 512'd0);
    chk("rst_blk_ready", 512'(blk_ready), 512'd0);
    chk("rst_g_start", 512'(g_start), 512'd0);
    chk("rst_g_m", g_m, 512'd0);
    chk("rst_digest_valid", 512'(digest_valid), 512'd0);
    chk("rst_err", 512'(err), 512'd0);

    // 1: empty message, 512-bit digest
    lat_lo = 1; lat_hi = 3;
    msg_q.delete();
    run_hash("t1", 1'b0, 1'b0);
    chk("t1_count", 512'(got_q.size()), 512'd3);
    if (got_q.size() >= 3) begin
      chk("t1_op0_n", got_q[0].n, 512'd0);
      chk("t1_op0_m", got_q[0].m, 512'd1);
      chk("t1_op1_n", got_q[1].n, 512'd0);
      chk("t1_op1_m", got_q[1].m, 512'd0);
      chk("t1_op2_n", got_q[2].n, 512'd0);
      chk("t1_op2_m", got_q[2].m, 512'd1);
    end

    // 2: 63-byte message, 256-bit digest
    msg_q.delete();
    for (int k = 0; k < 63; k++) msg_q.push_back(8'h30 + 8'(k % 3));
    run_hash("t2", 1'b1, 1'b0);
    if (got_q.size() >= 2) begin
      chk("t2_pad_byte63", 512'(got_q[0].m[511:504]), 512'h01);
      chk("t2_final_n", got_q[1].m, 512'd504);
    end
    chk("t2_dig_hi", {256'd0, dig_obs[511:256]}, 512'd0);

    // 3: single full 64-byte last block -> extra padding compression
    msg_q.delete();
    for (int k = 0; k < 64; k++) msg_q.push_back(8'($urandom));
    blkval = '0;
    for (int k = 0; k < 64; k++) blkval[8*k +: 8] = msg_q[k];
    run_hash("t3", 1'b0, 1'b0);
    chk("t3_count", 512'(got_q.size()), 512'd4);
    if (got_q.size() >= 4) begin
      chk("t3_pad_m", got_q[1].m, 512'd1);
      chk("t3_pad_n", got_q[1].n, 512'd512);
      chk("t3_finn_m", got_q[2].m, 512'd512);
      chk("t3_fins_m", got_q[3].m, blkval + 512'd1);
    end

    // 4: three full blocks + 10 bytes, long random latency, input stalls
    lat_lo = 1; lat_hi = 20;
    msg_q.delete();
    for (int k = 0; k < 202; k++) msg_q.push_back(8'($urandom));
    run_hash("t4", 1'b0, 1'b1);
    if (got_q.size() >= 6) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t4_nseq%0d", i), got_q[i].n, 512'(512 * i));
      chk("t4_final_n", got_q[4].m, 512'd1616);
      chk("t4_sigma", got_q[5].m, exp_sigma);
    end

    // 5: reset during FIN_N with a late g_done
    lat_lo = 15; lat_hi = 15;
    got_q.delete();
    pulse_start(1'b0);
    feed(512'($urandom), 1'b1, 7'd0, 1'b0);
    t = 0;
    while (got_q.size() < 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("t5_reach_fin_n", 512'(got_q.size()), 512'd2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_status", 512'(status), 512'd0);
    chk("t5_rst_blk_ready", 512'(blk_ready), 512'd0);
    chk("t5_rst_g_start", 512'(g_start), 512'd0);
    chk("t5_rst_g_h", g_h, 512'd0);
    chk("t5_rst_g_n", g_n, 512'd0);
    chk("t5_rst_g_m", g_m, 512'd0);
    chk("t5_rst_digest", digest, 512'd0);
    chk("t5_rst_dv", 512'(digest_valid), 512'd0);
    chk("t5_rst_err", 512'(err), 512'd0);
    repeat (30) @(negedge clk);
    chk("t5_late_status", 512'(status), 512'd0);
    chk("t5_late_nostart", 512'(got_q.size()), 512'd2);
    lat_lo = 1; lat_hi = 5;
    msg_q.delete();
    run_hash("t5_empty", 1'b0, 1'b0);

    // random messages
    for (int r = 0; r < 4; r++) begin
      lat_lo = 1; lat_hi = 8;
      msg_q.delete();
      t = $urandom_range(200, 0);
      for (int k = 0; k < t; k++) msg_q.push_back(8'($urandom));
      run_hash($sformatf("rnd%0d", r), 1'($urandom_range(1, 0)), 1'b1);
    end

    // 6: oversize byte count on the last block
    got_q.delete();
    pulse_start(1'b1);
    feed(512'($urandom), 1'b1, 7'd100, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_err", 512'(err), 512'd1);
    chk("t6_status", 512'(status), 512'd0);
    chk("t6_no_gstart", 512'(got_q.size()), 512'd0);
    pulse_start(1'b0);
    @(negedge clk);
    chk("t6_err_clr", 512'(err), 512'd0);
    chk("t6_ready", 512'(status), 512'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
